// File: rtl/sipo_piso_regif_pkg.sv
// Shared sizing constants and FSM state encoding for the serial register-file slave.
package sipo_piso_regif_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int REG_WIDTH  = 8;
  localparam int NUM_RW     = 9;
  localparam int NUM_RO     = 8;
  localparam int FRAME_LEN  = ADDR_WIDTH + REG_WIDTH;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_ADDR,
    READ_DATA
  } state_e;

endpackage

// File: rtl/sipo_piso_regfile.sv
// Writable register bank plus the read mux over writable and read-only registers.
module sipo_piso_regfile
  import sipo_piso_regif_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [REG_WIDTH-1:0]         wdata,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  input  logic [NUM_RO*REG_WIDTH-1:0]  ro_regs,
  output logic [NUM_RW*REG_WIDTH-1:0]  rw_regs,
  output logic [REG_WIDTH-1:0]         rdata
);

  logic [NUM_RW-1:0][REG_WIDTH-1:0] regs_q, regs_d;

  // Addresses at or above NUM_RW match no entry, so such writes drop naturally.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_RW; i++) begin
      if (we && waddr == ADDR_WIDTH'(i)) regs_d[i] = wdata;
    end
  end

  // NOTE: this bank must come up as zero, so it is a flop array with reset rather than a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  // NOTE: rdata is defaulted before the loops so unmatched addresses read 0 and no latch forms.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (raddr == ADDR_WIDTH'(i)) rdata = regs_q[i];
    end
    for (int m = 0; m < NUM_RO; m++) begin
      if (raddr == ADDR_WIDTH'(NUM_RW + m)) rdata = ro_regs[m*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign rw_regs = regs_q;

endmodule

// File: rtl/sipo_piso_regif.sv
// Serial register-file slave: strobe-framed LSB-first writes and reads over din/dout.
module sipo_piso_regif
  import sipo_piso_regif_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         strobe,
  input  logic                         wr_en,
  input  logic                         din,
  output logic                         dout,
  output logic                         rw_flag,
  output logic [NUM_RW*REG_WIDTH-1:0]  rw_regs,
  input  logic [NUM_RO*REG_WIDTH-1:0]  ro_regs
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [FRAME_LEN-2:0]   sr_q, sr_d;
  logic [REG_WIDTH-1:0]   out_sr_q, out_sr_d;
  logic                   dout_q, dout_d;
  logic                   rw_flag_q, rw_flag_d;

  logic                   we;
  logic [FRAME_LEN-1:0]   wr_word;
  logic [ADDR_WIDTH-1:0]  raddr;
  logic [REG_WIDTH-1:0]   rdata;

  // Bits enter at the MSB and drift down, so the last bit of a frame is still on din.
  assign wr_word = {din, sr_q};
  assign raddr   = {din, sr_q[FRAME_LEN-2 -: ADDR_WIDTH-1]};

  sipo_piso_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (wr_word[FRAME_LEN-1 -: ADDR_WIDTH]),
    .wdata   (wr_word[REG_WIDTH-1:0]),
    .raddr   (raddr),
    .ro_regs (ro_regs),
    .rw_regs (rw_regs),
    .rdata   (rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    out_sr_d  = out_sr_q;
    dout_d    = dout_q;
    rw_flag_d = rw_flag_q;
    we        = 1'b0;

    unique case (state_q)
      WRITE: begin
        sr_d  = {din, sr_q[FRAME_LEN-2:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(FRAME_LEN - 1)) begin
          we      = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      READ_ADDR: begin
        sr_d  = {din, sr_q[FRAME_LEN-2:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(ADDR_WIDTH - 1)) begin
          out_sr_d = rdata;
          dout_d   = rdata[0];
          cnt_d    = '0;
          state_d  = READ_DATA;
        end
      end
      READ_DATA: begin
        if (cnt_q == CNT_WIDTH'(REG_WIDTH - 1)) begin
          dout_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          out_sr_d = out_sr_q >> 1;
          dout_d   = out_sr_q[1];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A strobe restarts framing from any state and cancels a commit on the same edge.
    if (strobe) begin
      we        = 1'b0;
      cnt_d     = '0;
      rw_flag_d = wr_en;
      dout_d    = 1'b0;
      state_d   = wr_en ? WRITE : READ_ADDR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      out_sr_q  <= '0;
      dout_q    <= 1'b0;
      rw_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      out_sr_q  <= out_sr_d;
      dout_q    <= dout_d;
      rw_flag_q <= rw_flag_d;
    end
  end

  assign dout    = dout_q;
  assign rw_flag = rw_flag_q;

endmodule

// File: tb/tb_sipo_piso_regif.sv
// Directed self-checking bench for sipo_piso_regif; inputs change and outputs are sampled on negedges.
module tb_sipo_piso_regif;
  import sipo_piso_regif_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic strobe = 1'b0;
  logic wr_en = 1'b0;
  logic din = 1'b0;
  logic dout, rw_flag;
  logic [NUM_RW*REG_WIDTH-1:0] rw_regs;
  logic [NUM_RO*REG_WIDTH-1:0] ro_regs = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_rw [NUM_RW];

  always #5 clk = ~clk;

  sipo_piso_regif dut (
    .clk     (clk),
    .rst     (rst),
    .strobe  (strobe),
    .wr_en   (wr_en),
    .din     (din),
    .dout    (dout),
    .rw_flag (rw_flag),
    .rw_regs (rw_regs),
    .ro_regs (ro_regs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic wr);
    strobe = 1'b1;
    wr_en  = wr;
    din    = 1'b0;
    @(negedge clk);
    strobe = 1'b0;
    wr_en  = ~wr;
  endtask

  task automatic send_bits(input logic [12:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      din = w[i];
      @(negedge clk);
    end
    din = 1'b0;
  endtask

  task automatic wr_frame(input logic [4:0] a, input logic [7:0] d);
    start_frame(1'b1);
    send_bits({a, d}, 0, 12);
    check("wr_flag", 32'(rw_flag), 32'd1);
    if (a < 5'(NUM_RW)) exp_rw[a] = d;
  endtask

  task automatic rd_frame(input logic [4:0] a, output logic [7:0] d);
    start_frame(1'b0);
    send_bits({8'h00, a}, 0, 4);
    din = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = dout;
      if (i == 0) check("rd_flag", 32'(rw_flag), 32'd0);
      @(negedge clk);
    end
    check("rd_tail", 32'(dout), 32'd0);
    din   = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic check_rw_all(input string tag);
    for (int i = 0; i < NUM_RW; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(rw_regs[i*8 +: 8]), 32'(exp_rw[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] vals [8] = '{8'h2E, 8'h41, 8'h0E, 8'h00, 8'hD3, 8'h02, 8'h78, 8'h24};

    for (int i = 0; i < NUM_RW; i++) exp_rw[i] = 8'h00;
    for (int m = 0; m < NUM_RO; m++) ro_regs[m*8 +: 8] = 8'($urandom_range(1, 255));

    // Reset state
    #2;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flag", 32'(rw_flag), 32'd0);
    check("rst_regs", 32'(rw_regs == '0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic write/read of address 0
    wr_frame(5'd0, 8'hAE);
    check("wr0_reg", 32'(rw_regs[7:0]), 32'hAE);
    rd_frame(5'd0, rd);
    check("rd0", 32'(rd), 32'hAE);

    // Addresses 1..8
    for (int i = 0; i < 8; i++) wr_frame(5'(i + 1), vals[i]);
    check_rw_all("wr18");
    for (int i = 0; i < 8; i++) begin
      rd_frame(5'(i + 1), rd);
      check($sformatf("rd%0d", i + 1), 32'(rd), 32'(vals[i]));
    end

    // Read-only window: writes drop, reads return ro_regs slices
    for (int m = 0; m < NUM_RO; m++) wr_frame(5'(NUM_RW + m), ro_regs[m*8 +: 8]);
    check_rw_all("ro_wr");
    for (int m = 0; m < NUM_RO; m++) begin
      rd_frame(5'(NUM_RW + m), rd);
      check($sformatf("rd_ro%0d", m), 32'(rd), 32'(ro_regs[m*8 +: 8]));
    end

    // Unmapped address
    rd_frame(5'd20, rd);
    check("rd20", 32'(rd), 32'h00);

    // Asynchronous reset in the middle of a write to address 3
    start_frame(1'b1);
    send_bits({5'd3, 8'h5A}, 0, 6);
    #1 rst = 1'b0;
    for (int i = 0; i < NUM_RW; i++) exp_rw[i] = 8'h00;
    #1;
    check("mid_rst_r3", 32'(rw_regs[3*8 +: 8]), 32'h00);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_flag", 32'(rw_flag), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    send_bits({5'd3, 8'h5A}, 7, 12);
    @(negedge clk);
    check_rw_all("post_rst");
    wr_frame(5'd3, 8'h0E);
    rd_frame(5'd3, rd);
    check("rd3_after_rst", 32'(rd), 32'h0E);

    // Re-strobe at k=10 of a write to address 2
    start_frame(1'b1);
    send_bits({5'd2, 8'h55}, 0, 9);
    check("abort_r2", 32'(rw_regs[2*8 +: 8]), 32'h00);
    wr_frame(5'd2, 8'h33);
    check_rw_all("restrobe");
    rd_frame(5'd2, rd);
    check("rd2_restrobe", 32'(rd), 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
